// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared encodings and constants for the decode stage
package id_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        FWD_GPR = 2'b00,
        FWD_HI  = 2'b01,
        FWD_LO  = 2'b10
    } fwd_kind_e;

    localparam int REG_V0 = 2;
    localparam int REG_A0 = 4;
    localparam int REG_RA = 31;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - GPR file, two read ports, write-through bypass, r0 fixed at 0
module regfile_bypass #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wen;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    // Writes to r0 or to indices beyond the file are dropped.
    assign w_wen = i_we && (i_waddr != '0) && in_range(i_waddr);

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (a == '0 || !in_range(a))
            return '0;
        else if (w_wen && i_waddr == a)
            return i_wdata;
        else
            return r_regs[a];
    endfunction

    assign o_rdata1 = read_port(i_raddr1);
    assign o_rdata2 = read_port(i_raddr2);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wen) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/id_stage_fwd.sv
// rtl/id_stage_fwd.sv - decode stage: operand forwarding, load-use stall, ID/EX register
module id_stage_fwd
    import id_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = 32,
    parameter  int NFWD = 2,
    parameter  int CNTW = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               CLR,
    input  logic [31:0]        ir,
    input  logic               ir_valid,
    input  logic               syscall,
    input  logic               unsigned_imm,
    input  logic               reg_dst,
    input  logic               jal,
    input  logic               jr,
    input  logic               uses_rs,
    input  logic               uses_rt,
    input  logic               uses_hi,
    input  logic               uses_lo,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_num,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [XLEN-1:0]    hi_wdata,
    input  logic [XLEN-1:0]    lo_wdata,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [2*NFWD-1:0]  fwd_kind,
    input  logic [AW*NFWD-1:0] fwd_num,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic               ex_stall,
    input  logic               flush,
    output logic               id_stall,
    output logic [XLEN-1:0]    jaddr,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_rd1,
    output logic [XLEN-1:0]    ex_rd2,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_hi,
    output logic [XLEN-1:0]    ex_lo,
    output logic [4:0]         ex_shamt,
    output logic [AW-1:0]      ex_wbnum,
    output logic [CNTW-1:0]    stall_cnt
);

    logic [AW-1:0]   w_r1_idx, w_r2_idx, w_dst;
    logic [XLEN-1:0] w_rf1, w_rf2, w_hi_base, w_lo_base;
    logic [XLEN-1:0] w_r1, w_r2, w_hi, w_lo, w_imm;
    logic            w_r1_rdy, w_r2_rdy, w_hi_rdy, w_lo_rdy;
    logic            w_hazard;
    logic            w_unused_ir;

    logic [XLEN-1:0] r_hi, r_lo;
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_rd1, r_ex_rd2, r_ex_imm, r_ex_hi, r_ex_lo;
    logic [4:0]      r_ex_shamt;
    logic [AW-1:0]   r_ex_wbnum;
    logic [CNTW-1:0] r_stall_cnt;

    assign w_unused_ir = ^ir[31:26];

    assign w_r1_idx = syscall ? AW'(REG_V0) : AW'(ir[25:21]);
    assign w_r2_idx = syscall ? AW'(REG_A0) : AW'(ir[20:16]);
    assign w_dst    = jal     ? AW'(REG_RA)
                    : reg_dst ? AW'(ir[15:11]) : AW'(ir[20:16]);
    assign w_imm    = unsigned_imm ? XLEN'(ir[15:0]) : XLEN'($signed(ir[15:0]));

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .i_clk    (clk),
        .i_clr    (CLR),
        .i_we     (wb_we),
        .i_waddr  (wb_num),
        .i_wdata  (wb_data),
        .i_raddr1 (w_r1_idx),
        .i_raddr2 (w_r2_idx),
        .o_rdata1 (w_rf1),
        .o_rdata2 (w_rf2)
    );

    assign w_hi_base = hi_we ? hi_wdata : r_hi;
    assign w_lo_base = lo_we ? lo_wdata : r_lo;

    // Returns {ready, data}; walking downward lets the youngest match win.
    function automatic logic [XLEN:0] resolve(input fwd_kind_e kind,
                                              input logic [AW-1:0] idx,
                                              input logic [XLEN-1:0] base);
        logic [XLEN:0] res;
        res = {1'b1, base};
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_kind[2*i +: 2] == kind &&
                (kind != FWD_GPR || (fwd_num[AW*i +: AW] == idx && idx != '0)))
                res = {fwd_ready[i], fwd_data[XLEN*i +: XLEN]};
        end
        return res;
    endfunction

    assign {w_r1_rdy, w_r1} = resolve(FWD_GPR, w_r1_idx, w_rf1);
    assign {w_r2_rdy, w_r2} = resolve(FWD_GPR, w_r2_idx, w_rf2);
    assign {w_hi_rdy, w_hi} = resolve(FWD_HI, '0, w_hi_base);
    assign {w_lo_rdy, w_lo} = resolve(FWD_LO, '0, w_lo_base);

    assign w_hazard = (uses_rs & ~w_r1_rdy) | (uses_rt & ~w_r2_rdy) |
                      (uses_hi & ~w_hi_rdy) | (uses_lo & ~w_lo_rdy);

    assign id_stall = (ir_valid & w_hazard) | ex_stall;
    assign jaddr    = jr ? w_r1 : XLEN'(ir[25:0]);

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (hi_we)
                r_hi <= hi_wdata;
            if (lo_we)
                r_lo <= lo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_ex_valid <= 1'b0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_imm   <= '0;
            r_ex_hi    <= '0;
            r_ex_lo    <= '0;
            r_ex_shamt <= '0;
            r_ex_wbnum <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (ex_stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_valid <= ir_valid;
            r_ex_rd1   <= w_r1;
            r_ex_rd2   <= w_r2;
            r_ex_imm   <= w_imm;
            r_ex_hi    <= w_hi;
            r_ex_lo    <= w_lo;
            r_ex_shamt <= ir[10:6];
            r_ex_wbnum <= w_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (CLR)
            r_stall_cnt <= '0;
        else if (ir_valid && w_hazard && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign ex_valid  = r_ex_valid;
    assign ex_rd1    = r_ex_rd1;
    assign ex_rd2    = r_ex_rd2;
    assign ex_imm    = r_ex_imm;
    assign ex_hi     = r_ex_hi;
    assign ex_lo     = r_ex_lo;
    assign ex_shamt  = r_ex_shamt;
    assign ex_wbnum  = r_ex_wbnum;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_fwd.sv
// tb/tb_id_stage_fwd.sv - directed bench for id_stage_fwd
module tb_id_stage_fwd;
    import id_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NFWD = 2;
    localparam int CNTW = 4;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              CLR, ir_valid, syscall, unsigned_imm, reg_dst, jal, jr;
    logic              uses_rs, uses_rt, uses_hi, uses_lo;
    logic [31:0]       ir;
    logic              wb_we, hi_we, lo_we, ex_stall, flush;
    logic [AW-1:0]     wb_num;
    logic [XLEN-1:0]   wb_data, hi_wdata, lo_wdata;
    logic [NFWD-1:0]   fwd_valid, fwd_ready;
    logic [2*NFWD-1:0] fwd_kind;
    logic [AW*NFWD-1:0] fwd_num;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic              id_stall, ex_valid;
    logic [XLEN-1:0]   jaddr, ex_rd1, ex_rd2, ex_imm, ex_hi, ex_lo;
    logic [4:0]        ex_shamt;
    logic [AW-1:0]     ex_wbnum;
    logic [CNTW-1:0]   stall_cnt;

    id_stage_fwd #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .CNTW(CNTW)) dut (
        .clk(clk), .CLR(CLR), .ir(ir), .ir_valid(ir_valid), .syscall(syscall),
        .unsigned_imm(unsigned_imm), .reg_dst(reg_dst), .jal(jal), .jr(jr),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_hi(uses_hi), .uses_lo(uses_lo),
        .wb_we(wb_we), .wb_num(wb_num), .wb_data(wb_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .fwd_valid(fwd_valid), .fwd_kind(fwd_kind), .fwd_num(fwd_num),
        .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .jaddr(jaddr),
        .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_shamt(ex_shamt), .ex_wbnum(ex_wbnum),
        .stall_cnt(stall_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic [1:0] k,
                           input logic [4:0] n, input logic [31:0] d, input logic r);
        fwd_valid[i]          = v;
        fwd_kind[2*i +: 2]    = k;
        fwd_num[AW*i +: AW]   = n;
        fwd_data[XLEN*i +: XLEN] = d;
        fwd_ready[i]          = r;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    logic [25:0] jtarget;

    initial begin
        CLR = 1'b1; ir = rtype(5, 6, 3, 0); ir_valid = 1'b1;
        syscall = 0; unsigned_imm = 0; reg_dst = 1; jal = 0; jr = 0;
        uses_rs = 1; uses_rt = 1; uses_hi = 0; uses_lo = 0;
        wb_we = 0; wb_num = '0; wb_data = '0;
        hi_we = 0; lo_we = 0; hi_wdata = '0; lo_wdata = '0;
        fwd_valid = '0; fwd_kind = '0; fwd_num = '0; fwd_data = '0; fwd_ready = '0;
        ex_stall = 0; flush = 0;

        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_wbnum", 32'(ex_wbnum), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        CLR = 0;
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rd1", ex_rd1, 32'd0);
        chk("add_rd2", ex_rd2, 32'd0);
        chk("add_wbnum", 32'(ex_wbnum), 32'd3);

        // forwarding priority
        set_fwd(0, 1, FWD_GPR, 5, 32'h11, 1);
        set_fwd(1, 1, FWD_GPR, 5, 32'h22, 1);
        tick();
        chk("fwd_prio", ex_rd1, 32'h11);
        chk("fwd_rt_untouched", ex_rd2, 32'h0);
        set_fwd(0, 0, FWD_GPR, 5, 32'h11, 1);
        tick();
        chk("fwd_src1", ex_rd1, 32'h22);

        // load-use: young source not ready masks a ready older one
        set_fwd(0, 1, FWD_GPR, 5, 32'hEE, 0);
        #1;
        chk("lu_stall", 32'(id_stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_hold", ex_rd1, 32'h22);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        set_fwd(0, 1, FWD_GPR, 5, 32'hABCD, 1);
        #1;
        chk("lu_release", 32'(id_stall), 32'd0);
        tick();
        chk("lu_rd1", ex_rd1, 32'hABCD);
        chk("lu_valid", 32'(ex_valid), 32'd1);
        chk("lu_cnt2", 32'(stall_cnt), 32'd1);
        fwd_valid = '0;

        // write-through and stored value
        ir = rtype(0, 7, 3, 0); wb_we = 1; wb_num = 7; wb_data = 32'h55;
        tick();
        chk("wt_rd2", ex_rd2, 32'h55);
        chk("wt_rd1_r0", ex_rd1, 32'h0);
        wb_we = 0; ir = rtype(7, 0, 3, 0);
        tick();
        chk("stored_r7", ex_rd1, 32'h55);

        // r0 write is dropped
        wb_we = 1; wb_num = 0; wb_data = 32'h99; ir = rtype(0, 0, 3, 0);
        tick();
        chk("r0_wt", ex_rd1, 32'h0);
        wb_we = 0;
        tick();
        chk("r0_later", ex_rd1, 32'h0);

        // forward targeting r0 is ignored, including for hazard
        set_fwd(0, 1, FWD_GPR, 0, 32'hDEAD, 0);
        #1;
        chk("r0_fwd_nostall", 32'(id_stall), 32'd0);
        tick();
        chk("r0_fwd_rd1", ex_rd1, 32'h0);
        fwd_valid = '0;

        // HI/LO
        uses_lo = 1; lo_we = 1; lo_wdata = 32'h1234;
        tick();
        chk("lo_wt", ex_lo, 32'h1234);
        lo_we = 0; uses_hi = 1; hi_we = 1; hi_wdata = 32'h5678;
        tick();
        chk("hi_wt", ex_hi, 32'h5678);
        chk("lo_stored", ex_lo, 32'h1234);
        hi_we = 0;
        set_fwd(0, 1, FWD_LO, 0, 32'h77, 1);
        tick();
        chk("lo_fwd", ex_lo, 32'h77);
        chk("hi_unchanged", ex_hi, 32'h5678);
        fwd_valid = '0; uses_hi = 0; uses_lo = 0;

        // immediates
        ir = itype(0, 0, 16'h8000); reg_dst = 0;
        tick();
        chk("imm_signed", ex_imm, 32'hFFFF8000);
        unsigned_imm = 1;
        tick();
        chk("imm_unsigned", ex_imm, 32'h00008000);
        unsigned_imm = 0;

        // shamt, jal destination
        ir = rtype(0, 0, 9, 17); reg_dst = 1; jal = 1;
        tick();
        chk("shamt", 32'(ex_shamt), 32'd17);
        chk("jal_wbnum", 32'(ex_wbnum), 32'd31);
        jal = 0;
        tick();
        chk("rd_wbnum", 32'(ex_wbnum), 32'd9);

        // syscall reads v0/a0
        wb_we = 1; wb_num = 2; wb_data = 32'hC2;
        tick();
        wb_num = 4; wb_data = 32'hC4;
        tick();
        wb_we = 0; syscall = 1; ir = 32'h0000000C;
        tick();
        chk("sys_rd1", ex_rd1, 32'hC2);
        chk("sys_rd2", ex_rd2, 32'hC4);
        syscall = 0;

        // jump targets
        jtarget = 26'h2345678;
        ir = {6'h02, jtarget};
        #1;
        chk("jaddr_imm", jaddr, 32'h02345678);
        jr = 1; ir = rtype(2, 0, 0, 0);
        #1;
        chk("jaddr_jr", jaddr, 32'hC2);
        jr = 0;

        // control precedence
        ir = rtype(5, 6, 3, 0);
        set_fwd(0, 1, FWD_GPR, 5, 32'h500, 1);
        tick();
        chk("ctl_load", ex_rd1, 32'h500);
        flush = 1; ex_stall = 1; set_fwd(0, 1, FWD_GPR, 5, 32'h600, 1);
        #1;
        chk("ctl_idstall", 32'(id_stall), 32'd1);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_hold", ex_rd1, 32'h500);
        flush = 0; ex_stall = 0;
        tick();
        chk("ctl_reload", ex_rd1, 32'h600);
        ex_stall = 1; set_fwd(0, 1, FWD_GPR, 5, 32'h700, 1); ir = rtype(5, 6, 12, 0);
        tick();
        chk("exst_valid", 32'(ex_valid), 32'd1);
        chk("exst_rd1", ex_rd1, 32'h600);
        chk("exst_wbnum", 32'(ex_wbnum), 32'd3);
        chk("exst_cnt", 32'(stall_cnt), 32'd1);
        ex_stall = 0;

        // saturation of the stall counter
        set_fwd(0, 1, FWD_GPR, 5, 32'h0, 0);
        repeat (20) tick();
        chk("cnt_sat", 32'(stall_cnt), 32'd15);
        chk("sat_bubble", 32'(ex_valid), 32'd0);

        // reset during hazard
        CLR = 1;
        tick();
        chk("clr_valid", 32'(ex_valid), 32'd0);
        chk("clr_rd1", ex_rd1, 32'd0);
        chk("clr_wbnum", 32'(ex_wbnum), 32'd0);
        chk("clr_cnt", 32'(stall_cnt), 32'd0);
        CLR = 0;

        // hazard without a valid instruction is not counted
        ir_valid = 0;
        #1;
        chk("novalid_stall", 32'(id_stall), 32'd0);
        tick();
        chk("novalid_cnt", 32'(stall_cnt), 32'd0);
        fwd_valid = '0; ir_valid = 1; uses_lo = 1; ir = rtype(7, 0, 3, 0);
        tick();
        chk("clr_lo", ex_lo, 32'd0);
        chk("clr_r7", ex_rd1, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised second-generation instruction-decode stage for the pipelined MIPS core.
- Holds the GPR file and the HI/LO registers, extends immediates, and resolves operands through a priority forwarding network with NFWD sources.
- Detects load-use hazards and stalls on them.
- Drives a registered ID/EX pipeline register with stall and flush control, plus a stall performance counter.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of GPRs; AW = clog2(NREG).
- NFWD, 2, number of forwarding sources; index 0 is the youngest stage and has the highest priority.
- CNTW, 16, width of the stall counter.

Ports:
- clk  in  1  clock
- CLR  in  1  synchronous active-high reset
- ir  in  32  instruction word
- ir_valid  in  1  ir holds a real instruction
- syscall, unsigned_imm, reg_dst, jal, jr  in  1 each  decode controls
- uses_rs, uses_rt, uses_hi, uses_lo  in  1 each  operand-use flags
- wb_we  in  1  GPR write enable
- wb_num  in  AW  GPR write index
- wb_data  in  XLEN  GPR write data
- hi_we, lo_we  in  1 each  HI/LO write enables
- hi_wdata, lo_wdata  in  XLEN each  HI/LO write data
- fwd_valid  in  NFWD  source i holds a pending write
- fwd_kind  in  2*NFWD  target of source i: 00 GPR, 01 HI, 10 LO
- fwd_num  in  AW*NFWD  GPR index of source i
- fwd_data  in  XLEN*NFWD  result of source i
- fwd_ready  in  NFWD  fwd_data of source i is available (0 = load still in flight)
- ex_stall  in  1  EX back-pressure
- flush  in  1  kill the instruction entering EX
- id_stall  out  1  combinational; freeze IF and ID
- jaddr  out  XLEN  combinational jump target
- ex_valid  out  1  registered ID/EX valid
- ex_rd1, ex_rd2, ex_imm, ex_hi, ex_lo  out  XLEN each  registered operands
- ex_shamt  out  5  registered shift amount
- ex_wbnum  out  AW  registered destination index
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- Reset (CLR high at a posedge): all GPRs, HI, LO, all ex_* outputs and stall_cnt are cleared to 0. Reset overrides simultaneous writes, stall and flush.
- Register sources:
  - R1 index = syscall ? 2 : ir[25:21].
  - R2 index = syscall ? 4 : ir[20:16].
- Destination: ex_wbnum source = jal ? 31 : (reg_dst ? ir[15:11] : ir[20:16]).
- Immediate: ir[15:0], zero-extended when unsigned_imm is high, sign-extended otherwise, to XLEN.
- Shift amount: ex_shamt = ir[10:6].
- GPR writes occur at posedge when wb_we is high and wb_num != 0. Register 0 always reads 0. wb_num >= NREG is ignored.
- Operand resolution, per operand, in priority order:
  1. Lowest-index source i with fwd_valid[i], matching kind, and (for GPR) fwd_num[i] == index and index != 0 supplies fwd_data[i].
  2. Otherwise the same-cycle WB write supplies its data (write-through bypass; this also applies to HI/LO).
  3. Otherwise the stored value.
- Hazard: if the winning source for any used operand has fwd_ready = 0, the hazard is true. Lower-priority ready sources are not consulted.
- jaddr = jr ? resolved R1 : zero-extended ir[25:0]. jaddr is don't-care while a hazard is active.
- id_stall = ir_valid & hazard, OR ex_stall.
- ID/EX register update at posedge, in this priority:
  1. CLR.
  2. flush: ex_valid <= 0; data fields hold.
  3. ex_stall: all ex_* hold.
  4. hazard: ex_valid <= 0 (bubble); data fields hold.
  5. Otherwise: load all fields, ex_valid <= ir_valid.
- stall_cnt increments by 1 on every cycle with ir_valid & hazard & !CLR, and saturates at all-ones. ex_stall cycles are not counted.

Decomposition:
- Package id_pkg holds:
  - FWD_GPR, FWD_HI, FWD_LO kind encodings;
  - REG_V0 = 2, REG_A0 = 4, REG_RA = 31;
  - the default XLEN.
- Sub-module regfile_bypass (parameters XLEN, NREG): two read ports, one write port, write-through bypass, r0 hardwired to 0.
- The HI/LO pair, the forwarding priority loop, the hazard logic and the ID/EX register stay in id_stage_fwd.

Test Plan:
- Reset, then read r5: CLR for 1 cycle, ir = add rd=3 rs=5 rt=6 -> next cycle ex_valid = 1, ex_rd1 = 0, ex_rd2 = 0, ex_wbnum = 3.
- Forward priority: fwd0 = {GPR, r5, 0x11, ready} and fwd1 = {GPR, r5, 0x22, ready} -> ex_rd1 = 0x11. With only fwd1 valid -> ex_rd1 = 0x22.
- Load-use: fwd0 = {GPR, r5, ready = 0}, uses_rs = 1 -> id_stall = 1, then ex_valid = 0 and stall_cnt = 1. Next cycle ready = 1, data 0xABCD -> ex_rd1 = 0xABCD, ex_valid = 1.
- Write-through and r0:
  - wb_we = 1, wb_num = 7, data 0x55 in the same cycle ir reads r7 -> ex_rd2 = 0x55.
  - wb_num = 0, data 0x99 -> a later read of r0 returns 0.
  - fwd to r0 is ignored.
- HI/LO and immediates:
  - lo_we = 1 with 0x1234 -> LO reads 0x1234 in the same cycle.
  - fwd0 kind LO, 0x77 -> ex_lo = 0x77 and ex_hi unchanged.
  - imm 0x8000 -> 0xFFFF8000 signed, 0x00008000 unsigned.
- Control precedence: flush and ex_stall together -> ex_valid = 0. ex_stall alone holds all ex_* values. CLR during a hazard -> all outputs 0 and stall_cnt = 0.
